// File: rtl/idex_hazard_stage_pkg.sv
// Shared constants and types for the ID/EX hazard stage: register ids,
// writeback codes and the memory-control slice forced by a bubble.
package idex_hazard_stage_pkg;

    localparam logic [3:0] REG_ZERO  = 4'd0;
    localparam logic [3:0] REG_PC    = 4'd15;
    localparam logic [2:0] REGW_NONE = 3'b000;

    typedef struct packed {
        logic [2:0] regWrite;
        logic       memRead;
        logic       memWrite;
    } idex_mem_ctl_t;

    localparam idex_mem_ctl_t BUBBLE_CTL = '{regWrite: REGW_NONE, memRead: 1'b0, memWrite: 1'b0};

endpackage

// File: rtl/idex_hazard_stage_if.sv
// Decode-to-execute bundle: decoded ID fields in, registered ID/EX fields,
// stall and bubble count out.
interface idex_hazard_stage_if #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 8
);
    logic        [3:0]        ifidOP1;
    logic        [3:0]        ifidOP2;
    logic        [2:0]        idregWrite;
    logic                     idmemRead;
    logic                     idmemWrite;
    logic        [CTRL_W-1:0] idCtrl;
    logic signed [DATA_W-1:0] idA;
    logic signed [DATA_W-1:0] idB;
    logic signed [DATA_W-1:0] idImm;
    logic                     exBusy;
    logic                     flush;

    logic        [3:0]        idexOP1;
    logic        [3:0]        idexOP2;
    logic        [2:0]        idexregWrite;
    logic                     idexmemRead;
    logic                     idexmemWrite;
    logic        [CTRL_W-1:0] idexCtrl;
    logic signed [DATA_W-1:0] idexA;
    logic signed [DATA_W-1:0] idexB;
    logic signed [DATA_W-1:0] idexImm;
    logic                     stall;
    logic        [CNT_W-1:0]  bubbleCnt;

    modport master (
        output ifidOP1, ifidOP2, idregWrite, idmemRead, idmemWrite, idCtrl,
               idA, idB, idImm, exBusy, flush,
        input  idexOP1, idexOP2, idexregWrite, idexmemRead, idexmemWrite, idexCtrl,
               idexA, idexB, idexImm, stall, bubbleCnt
    );

    modport slave (
        input  ifidOP1, ifidOP2, idregWrite, idmemRead, idmemWrite, idCtrl,
               idA, idB, idImm, exBusy, flush,
        output idexOP1, idexOP2, idexregWrite, idexmemRead, idexmemWrite, idexCtrl,
               idexA, idexB, idexImm, stall, bubbleCnt
    );

endinterface

// File: rtl/idex_hazard_stage_load_use.sv
// Load-use detector: a load in EX whose destination is read by the
// instruction in ID. Register 0 is hardwired and never hazards.
module load_use_detect
    import idex_hazard_stage_pkg::*;
(
    input  logic [3:0] i_ex_op1,
    input  logic [2:0] i_ex_regwrite,
    input  logic       i_ex_memread,
    input  logic [3:0] i_id_op1,
    input  logic [3:0] i_id_op2,
    output logic       o_haz
);

    logic w_ex_writes_reg;
    logic w_src_match;

    assign w_ex_writes_reg = i_ex_memread && (i_ex_regwrite != REGW_NONE) && (i_ex_op1 != REG_ZERO);
    // OP1 is checked too: stores read their data register through OP1.
    assign w_src_match     = (i_ex_op1 == i_id_op1) || (i_ex_op1 == i_id_op2);
    assign o_haz           = w_ex_writes_reg && w_src_match;

endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion, branch
// flush, multi-cycle EX hold and a saturating bubble counter.
module idex_hazard_stage
    import idex_hazard_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 8
) (
    input logic              clk,
    input logic              reset,
    idex_hazard_stage_if.slave bus
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic        [3:0]        r_op1_p1;
    logic        [3:0]        r_op2_p1;
    idex_mem_ctl_t            r_mem_p1;
    logic        [CTRL_W-1:0] r_ctrl_p1;
    logic signed [DATA_W-1:0] r_a_p1;
    logic signed [DATA_W-1:0] r_b_p1;
    logic signed [DATA_W-1:0] r_imm_p1;
    logic        [CNT_W-1:0]  r_bubble_cnt;
    logic                     w_haz;

    load_use_detect u_load_use_detect (
        .i_ex_op1      (r_op1_p1),
        .i_ex_regwrite (r_mem_p1.regWrite),
        .i_ex_memread  (r_mem_p1.memRead),
        .i_id_op1      (bus.ifidOP1),
        .i_id_op2      (bus.ifidOP2),
        .o_haz         (w_haz)
    );

    // ID -> EX boundary: hold on exBusy, else flush/hazard bubble, else capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op1_p1     <= '0;
            r_op2_p1     <= '0;
            r_mem_p1     <= BUBBLE_CTL;
            r_ctrl_p1    <= '0;
            r_a_p1       <= '0;
            r_b_p1       <= '0;
            r_imm_p1     <= '0;
            r_bubble_cnt <= '0;
        end else if (!bus.exBusy) begin
            if (bus.flush || w_haz) begin
                r_op1_p1  <= '0;
                r_op2_p1  <= '0;
                r_mem_p1  <= BUBBLE_CTL;
                r_ctrl_p1 <= '0;
                r_a_p1    <= '0;
                r_b_p1    <= '0;
                r_imm_p1  <= '0;
                // A flushed instruction never needed the stall, so it is not counted.
                if (!bus.flush)
                    r_bubble_cnt <= sat_inc(r_bubble_cnt);
            end else begin
                r_op1_p1  <= bus.ifidOP1;
                r_op2_p1  <= bus.ifidOP2;
                r_mem_p1  <= '{regWrite: bus.idregWrite, memRead: bus.idmemRead, memWrite: bus.idmemWrite};
                r_ctrl_p1 <= bus.idCtrl;
                r_a_p1    <= bus.idA;
                r_b_p1    <= bus.idB;
                r_imm_p1  <= bus.idImm;
            end
        end
    end

    assign bus.idexOP1      = r_op1_p1;
    assign bus.idexOP2      = r_op2_p1;
    assign bus.idexregWrite = r_mem_p1.regWrite;
    assign bus.idexmemRead  = r_mem_p1.memRead;
    assign bus.idexmemWrite = r_mem_p1.memWrite;
    assign bus.idexCtrl     = r_ctrl_p1;
    assign bus.idexA        = r_a_p1;
    assign bus.idexB        = r_b_p1;
    assign bus.idexImm      = r_imm_p1;
    assign bus.stall        = w_haz | bus.exBusy;
    assign bus.bubbleCnt    = r_bubble_cnt;

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Directed bench for idex_hazard_stage: reset, load-use bubble, R0 exemption,
// EX hold, flush priority, back-to-back loads, reset mid-stall, saturation.
module tb_idex_hazard_stage;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    idex_hazard_stage_if #(.DATA_W(16), .CTRL_W(8), .CNT_W(8)) bus ();

    idex_hazard_stage #(.DATA_W(16), .CTRL_W(8), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic [3:0] op1, input logic [3:0] op2, input logic [2:0] rw,
                            input logic mr, input logic mw, input logic [7:0] ctrl,
                            input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm);
        bus.ifidOP1 = op1; bus.ifidOP2 = op2; bus.idregWrite = rw;
        bus.idmemRead = mr; bus.idmemWrite = mw; bus.idCtrl = ctrl;
        bus.idA = a; bus.idB = b; bus.idImm = imm;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.exBusy = 1'b0;
        bus.flush  = 1'b1;
        drive_id(4'hA, 4'hB, 3'd5, 1'b1, 1'b1, 8'hFF, 16'h1111, 16'h2222, 16'h3333);
        step(); step();
        n_cmp++; if (bus.idexOP1 !== 4'd0 || bus.idexOP2 !== 4'd0) begin n_err++; $display("FAIL reset_ops: got %h/%h want 0/0", bus.idexOP1, bus.idexOP2); end
        n_cmp++; if (bus.idexregWrite !== 3'd0 || bus.idexmemRead !== 1'b0 || bus.idexmemWrite !== 1'b0) begin n_err++; $display("FAIL reset_mem: got %h/%b/%b want 0/0/0", bus.idexregWrite, bus.idexmemRead, bus.idexmemWrite); end
        n_cmp++; if (bus.idexCtrl !== 8'd0 || bus.idexA !== 16'sd0 || bus.idexB !== 16'sd0 || bus.idexImm !== 16'sd0) begin n_err++; $display("FAIL reset_data: got %h/%h/%h/%h want 0", bus.idexCtrl, bus.idexA, bus.idexB, bus.idexImm); end
        n_cmp++; if (bus.stall !== 1'b0 || bus.bubbleCnt !== 8'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %b/%0d want 0/0", bus.stall, bus.bubbleCnt); end
        bus.flush = 1'b0;
        reset = 1'b0;
        drive_id(4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 8'h00, 16'h0, 16'h0, 16'h0);
        step();
    endtask

    task automatic test_load_use();
        drive_id(4'd3, 4'd1, 3'd1, 1'b1, 1'b0, 8'h11, 16'h0010, 16'h0020, 16'h0004);
        step();
        drive_id(4'd5, 4'd3, 3'd1, 1'b0, 1'b0, 8'h22, 16'h1234, 16'h5678, 16'hFFFE);
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", bus.stall); end
        step();
        n_cmp++; if (bus.idexregWrite !== 3'd0 || bus.idexmemRead !== 1'b0 || bus.idexCtrl !== 8'd0) begin n_err++; $display("FAIL lu_bubble: got %h/%b/%h want 0/0/0", bus.idexregWrite, bus.idexmemRead, bus.idexCtrl); end
        n_cmp++; if (bus.bubbleCnt !== 8'd1 || bus.stall !== 1'b0) begin n_err++; $display("FAIL lu_cnt_stall: got %0d/%b want 1/0", bus.bubbleCnt, bus.stall); end
        step();
        n_cmp++; if (bus.idexOP1 !== 4'd5 || bus.idexOP2 !== 4'd3 || bus.idexregWrite !== 3'd1 || bus.idexCtrl !== 8'h22) begin n_err++; $display("FAIL lu_capture: got %h/%h/%h/%h want 5/3/1/22", bus.idexOP1, bus.idexOP2, bus.idexregWrite, bus.idexCtrl); end
        n_cmp++; if (bus.idexA !== 16'sh1234 || bus.idexB !== 16'sh5678 || bus.idexImm !== 16'shFFFE || bus.stall !== 1'b0) begin n_err++; $display("FAIL lu_capture_data: got %h/%h/%h stall %b want 1234/5678/fffe 0", bus.idexA, bus.idexB, bus.idexImm, bus.stall); end
    endtask

    task automatic test_reg_zero();
        drive_id(4'd0, 4'd0, 3'd1, 1'b1, 1'b0, 8'h31, 16'h0001, 16'h0002, 16'h0003);
        step();
        drive_id(4'd0, 4'd0, 3'd1, 1'b0, 1'b0, 8'h32, 16'h0AAA, 16'h0BBB, 16'h0CCC);
        n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL r0_stall: got %b want 0", bus.stall); end
        step();
        n_cmp++; if (bus.idexCtrl !== 8'h32 || bus.idexA !== 16'sh0AAA || bus.bubbleCnt !== 8'd1) begin n_err++; $display("FAIL r0_capture: got %h/%h/%0d want 32/0aaa/1", bus.idexCtrl, bus.idexA, bus.bubbleCnt); end
        // Load with no writeback never hazards.
        drive_id(4'd4, 4'd0, 3'd0, 1'b1, 1'b0, 8'h33, 16'h0, 16'h0, 16'h0);
        step();
        drive_id(4'd4, 4'd4, 3'd1, 1'b0, 1'b0, 8'h34, 16'h0, 16'h0, 16'h0);
        n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL nowb_stall: got %b want 0", bus.stall); end
        step();
    endtask

    task automatic test_exbusy();
        drive_id(4'd7, 4'd2, 3'd1, 1'b1, 1'b0, 8'h33, 16'h0707, 16'h0202, 16'h0009);
        step();
        drive_id(4'd7, 4'd1, 3'd1, 1'b0, 1'b0, 8'h44, 16'h4444, 16'h5555, 16'h6666);
        bus.exBusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.flush = (i == 1);
            #1;
            n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL busy_stall[%0d]: got %b want 1", i, bus.stall); end
            step();
            n_cmp++; if (bus.idexOP1 !== 4'd7 || bus.idexmemRead !== 1'b1 || bus.idexCtrl !== 8'h33 || bus.idexA !== 16'sh0707 || bus.bubbleCnt !== 8'd1) begin n_err++; $display("FAIL busy_hold[%0d]: got %h/%b/%h/%h/%0d want 7/1/33/0707/1", i, bus.idexOP1, bus.idexmemRead, bus.idexCtrl, bus.idexA, bus.bubbleCnt); end
        end
        bus.flush  = 1'b0;
        bus.exBusy = 1'b0;
        #1;
        step();
        n_cmp++; if (bus.idexmemRead !== 1'b0 || bus.idexregWrite !== 3'd0 || bus.bubbleCnt !== 8'd2) begin n_err++; $display("FAIL busy_release: got %b/%h/%0d want 0/0/2", bus.idexmemRead, bus.idexregWrite, bus.bubbleCnt); end
        step();
        n_cmp++; if (bus.idexCtrl !== 8'h44 || bus.idexB !== 16'sh5555) begin n_err++; $display("FAIL busy_capture: got %h/%h want 44/5555", bus.idexCtrl, bus.idexB); end
    endtask

    task automatic test_flush();
        drive_id(4'd9, 4'd0, 3'd1, 1'b1, 1'b0, 8'h55, 16'h0009, 16'h0, 16'h0);
        step();
        drive_id(4'd1, 4'd9, 3'd2, 1'b0, 1'b1, 8'h66, 16'h6001, 16'h6002, 16'h6003);
        bus.flush = 1'b1;
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL flush_stall: got %b want 1", bus.stall); end
        step();
        n_cmp++; if (bus.idexmemRead !== 1'b0 || bus.idexmemWrite !== 1'b0 || bus.idexCtrl !== 8'd0 || bus.bubbleCnt !== 8'd2) begin n_err++; $display("FAIL flush_bubble: got %b/%b/%h/%0d want 0/0/0/2", bus.idexmemRead, bus.idexmemWrite, bus.idexCtrl, bus.bubbleCnt); end
        bus.flush = 1'b0;
        #1;
        step();
        n_cmp++; if (bus.idexOP2 !== 4'd9 || bus.idexmemWrite !== 1'b1 || bus.idexImm !== 16'sh6003) begin n_err++; $display("FAIL flush_after: got %h/%b/%h want 9/1/6003", bus.idexOP2, bus.idexmemWrite, bus.idexImm); end
    endtask

    task automatic test_back_to_back();
        drive_id(4'd2, 4'd0, 3'd1, 1'b1, 1'b0, 8'h70, 16'h0, 16'h0, 16'h0);
        step();
        drive_id(4'd4, 4'd2, 3'd1, 1'b1, 1'b0, 8'h71, 16'h0, 16'h0, 16'h0);
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall1: got %b want 1", bus.stall); end
        step();
        n_cmp++; if (bus.bubbleCnt !== 8'd3 || bus.stall !== 1'b0) begin n_err++; $display("FAIL b2b_bubble1: got %0d/%b want 3/0", bus.bubbleCnt, bus.stall); end
        step();
        drive_id(4'd8, 4'd4, 3'd1, 1'b0, 1'b0, 8'h72, 16'h0, 16'h0, 16'h0);
        n_cmp++; if (bus.idexOP1 !== 4'd4 || bus.idexmemRead !== 1'b1 || bus.stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall2: got %h/%b/%b want 4/1/1", bus.idexOP1, bus.idexmemRead, bus.stall); end
        step();
        n_cmp++; if (bus.bubbleCnt !== 8'd4) begin n_err++; $display("FAIL b2b_bubble2: got %0d want 4", bus.bubbleCnt); end
        step();
        n_cmp++; if (bus.idexCtrl !== 8'h72) begin n_err++; $display("FAIL b2b_capture: got %h want 72", bus.idexCtrl); end
    endtask

    task automatic test_reset_mid_stall();
        drive_id(4'd6, 4'd0, 3'd1, 1'b1, 1'b0, 8'h80, 16'h0, 16'h0, 16'h0);
        step();
        drive_id(4'd6, 4'd6, 3'd1, 1'b0, 1'b0, 8'h81, 16'h0, 16'h0, 16'h0);
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre: got %b want 1", bus.stall); end
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (bus.stall !== 1'b0 || bus.idexmemRead !== 1'b0 || bus.idexOP1 !== 4'd0 || bus.bubbleCnt !== 8'd0) begin n_err++; $display("FAIL rst_mid: got %b/%b/%h/%0d want 0/0/0/0", bus.stall, bus.idexmemRead, bus.idexOP1, bus.bubbleCnt); end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_saturate();
        for (int i = 1; i <= 300; i++) begin
            drive_id(4'd1, 4'd0, 3'd1, 1'b1, 1'b0, 8'h90, 16'h0, 16'h0, 16'h0);
            step();
            drive_id(4'd2, 4'd1, 3'd1, 1'b0, 1'b0, 8'h91, 16'h0, 16'h0, 16'h0);
            step();
            if (i == 200) begin
                n_cmp++; if (bus.bubbleCnt !== 8'd200) begin n_err++; $display("FAIL sat_200: got %0d want 200", bus.bubbleCnt); end
            end
            if (i == 255) begin
                n_cmp++; if (bus.bubbleCnt !== 8'd255) begin n_err++; $display("FAIL sat_255: got %0d want 255", bus.bubbleCnt); end
            end
        end
        n_cmp++; if (bus.bubbleCnt !== 8'd255) begin n_err++; $display("FAIL sat_300: got %0d want 255", bus.bubbleCnt); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_load_use();
        test_reg_zero();
        test_exbusy();
        test_flush();
        test_back_to_back();
        test_reset_mid_stall();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
